// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: decodes two-beam gate sensors into entry/exit count ticks with saturating occupancy.
// Define PARK_SYNC_EN to pass the sensors through 2-flop synchronizers (adds 2 cycles of latency).
module parking_gate_ctrl #(
  parameter int CAPACITY = 9999,
  parameter int CNT_W    = 14
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sensor_a_i,
  input  logic             sensor_b_i,
  output logic             tick_o,
  output logic             sign_o,
  output logic [CNT_W-1:0] occupancy_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             reject_o,
  output logic             error_o
);
  typedef enum logic [2:0] {IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_AB, EXT_A, ERROR} state_e;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  state_e           state_q, state_d;
  logic [1:0]       ab;
  logic             tick_q, tick_d, sign_q, sign_d, reject_q, reject_d, ent_ev, ext_ev;
  logic [CNT_W-1:0] occ_q, occ_d;
`ifdef PARK_SYNC_EN
  logic [1:0] sync_a_q, sync_b_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[0], sensor_a_i};
      sync_b_q <= {sync_b_q[0], sensor_b_i};
    end
  assign ab = {sync_a_q[1], sync_b_q[1]};
`else
  assign ab = {sensor_a_i, sensor_b_i};
`endif
  // exit states mirror the entry states with the two beams swapped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = ab == 2'b10 ? ENT_A  : ab == 2'b01 ? EXT_B : ab == 2'b11 ? ERROR : IDLE;
      ENT_A:   state_d = ab == 2'b11 ? ENT_AB : ab == 2'b00 ? IDLE  : ab == 2'b01 ? ERROR : ENT_A;
      ENT_AB:  state_d = ab == 2'b01 ? ENT_B  : ab == 2'b10 ? ENT_A : ab == 2'b00 ? ERROR : ENT_AB;
      ENT_B:   state_d = ab == 2'b11 ? ENT_AB : ab == 2'b00 ? IDLE  : ab == 2'b10 ? ERROR : ENT_B;
      EXT_B:   state_d = ab == 2'b11 ? EXT_AB : ab == 2'b00 ? IDLE  : ab == 2'b10 ? ERROR : EXT_B;
      EXT_AB:  state_d = ab == 2'b10 ? EXT_A  : ab == 2'b01 ? EXT_B : ab == 2'b00 ? ERROR : EXT_AB;
      EXT_A:   state_d = ab == 2'b11 ? EXT_AB : ab == 2'b00 ? IDLE  : ab == 2'b01 ? ERROR : EXT_A;
      default: state_d = ab == 2'b00 ? IDLE   : ERROR;
    endcase
  end
  always_comb begin
    ent_ev   = state_q == ENT_B && ab == 2'b00;
    ext_ev   = state_q == EXT_A && ab == 2'b00;
    tick_d   = (ent_ev && occ_q < CAP) || (ext_ev && occ_q != '0);
    reject_d = (ent_ev || ext_ev) && !tick_d;
    sign_d   = tick_d ? ent_ev : sign_q;
    occ_d    = !tick_d ? occ_q : ent_ev ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= IDLE;
      tick_q   <= 1'b0;
      sign_q   <= 1'b1;
      reject_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      sign_q   <= sign_d;
      reject_q <= reject_d;
      occ_q    <= occ_d;
    end
  assign tick_o      = tick_q;
  assign sign_o      = sign_q;
  assign reject_o    = reject_q;
  assign occupancy_o = occ_q;
  assign full_o      = occ_q == CAP;
  assign empty_o     = occ_q == '0;
  assign error_o     = state_q == ERROR;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed and random gate traffic checked against a car-position reference model.
module tb_parking_gate_ctrl;
  localparam int CAP = 6;
  localparam int W   = 3;
`ifdef PARK_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int LAT  = 3;
`else
  localparam bit SYNC = 1'b0;
  localparam int LAT  = 1;
`endif
  logic         clk = 1'b0, rst_n = 1'b0, sa = 1'b0, sb = 1'b0;
  logic         tick, sign, full, empty, reject, error;
  logic [W-1:0] occupancy;
  int           checks = 0, errors = 0, ticks_seen = 0, rejects_seen = 0;
  int           m_occ, m_dir, m_k;
  bit           m_err, m_tick, m_rej, m_sign;
  logic [1:0]   p0, p1;

  parking_gate_ctrl #(.CAPACITY(CAP), .CNT_W(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sensor_a_i(sa), .sensor_b_i(sb),
    .tick_o(tick), .sign_o(sign), .occupancy_o(occupancy), .full_o(full),
    .empty_o(empty), .reject_o(reject), .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_dir = 0; m_k = 0; m_err = 0; m_tick = 0; m_rej = 0; m_sign = 1; p0 = '0; p1 = '0;
  endtask

  // car position along its path: entry 00,10,11,01,00 (exit uses the beams swapped); moves of one step are legal
  task automatic model_edge();
    logic [1:0] s, e;
    int j;
    s  = SYNC ? p1 : {sa, sb};
    p1 = p0;
    p0 = {sa, sb};
    m_tick = 0;
    m_rej  = 0;
    if (m_err) m_err = (s != 2'b00);
    else if (m_dir == 0) begin
      if (s == 2'b11) m_err = 1;
      else if (s != 2'b00) begin
        m_dir = (s == 2'b10) ? 1 : -1;
        m_k   = 1;
      end
    end else begin
      e = (m_dir > 0) ? s : {s[0], s[1]};
      j = e == 2'b10 ? 1 : e == 2'b11 ? 2 : e == 2'b01 ? 3 : (m_k == 1 ? 0 : 4);
      if (j - m_k > 1 || m_k - j > 1) begin
        m_err = 1;
        m_dir = 0;
      end else if (j == 0) m_dir = 0;
      else if (j == 4) begin
        if (m_dir > 0 ? m_occ < CAP : m_occ > 0) begin
          m_tick = 1;
          m_sign = m_dir > 0;
          m_occ += m_dir;
        end else m_rej = 1;
        m_dir = 0;
      end else m_k = j;
    end
  endtask

  task automatic check_all();
    chk("tick", tick, m_tick);
    chk("sign", sign, m_sign);
    chk("reject", reject, m_rej);
    chk("occupancy", occupancy, m_occ);
    chk("full", full, m_occ == CAP);
    chk("empty", empty, m_occ == 0);
    chk("error", error, m_err);
  endtask

  task automatic step(input logic [1:0] ab);
    {sa, sb} = ab;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    ticks_seen   += int'(tick);
    rejects_seen += int'(reject);
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    for (int i = 0; i < n; i++) step(ab);
  endtask

  task automatic car(input bit entry, input int n);
    logic [1:0] ent [4];
    ent = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) hold(entry ? ent[i] : {ent[i][0], ent[i][1]}, n);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    hold(2'b00, 3);
    ticks_seen = 0;
    car(1, 3);
    chk("entry_ticks", ticks_seen, 1);
    chk("entry_occ", occupancy, 1);
    chk("entry_sign", sign, 1);
    ticks_seen = 0;
    car(0, 3);
    chk("exit_ticks", ticks_seen, 1);
    chk("exit_empty", empty, 1);
    ticks_seen = 0; rejects_seen = 0;
    car(0, 3);
    chk("empty_exit_ticks", ticks_seen, 0);
    chk("empty_exit_reject", rejects_seen, 1);
    ticks_seen = 0; rejects_seen = 0;
    hold(2'b10, 3); hold(2'b00, 3);
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b00, 3);
    chk("abort_ticks", ticks_seen + rejects_seen, 0);
    hold(2'b11, 1);
    hold(2'b01, 3);
    chk("error_held", error, 1);
    hold(2'b00, 3);
    chk("error_cleared", error, 0);
    chk("error_ticks", ticks_seen, 0);
    car(1, 2);
    chk("after_error_occ", occupancy, 1);
    ticks_seen = 0; rejects_seen = 0;
    for (int i = 0; i < 6; i++) car(1, 2);
    chk("cap_ticks", ticks_seen, 5);
    chk("cap_reject", rejects_seen, 1);
    chk("cap_full", full, 1);
    chk("cap_occ", occupancy, CAP);
    car(0, 2);
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    hold(2'b00, 2);
    @(negedge clk);
    rst_n = 1'b1;
    ticks_seen = 0;
    hold(2'b00, 4);
    chk("reset_no_tick", ticks_seen, 0);
    car(1, 3);
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3);
    {sa, sb} = 2'b00;
    n = 0;
    do begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      n++;
    end while (!tick && n < 8);
    chk("latency", n, LAT);
    hold(2'b00, 2);
    for (int i = 0; i < 200; i++) hold(2'($urandom_range(3)), int'($urandom_range(1, 3)));
    hold(2'b00, 3);
    for (int i = 0; i < 30; i++) car(1'($urandom_range(1)), int'($urandom_range(1, 3)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
